sobel_window_core: RTL and testbench

//  Consumes the line-buffer stage outputs: three vertically aligned gray pixels per step plus the middle-row RGB.

---
 rtl/sobel_window_core_pkg.sv | 17 +
 rtl/sobel_window_core_win.sv | 69 ++++++
 rtl/sobel_window_core.sv | 111 +++++++++++
 tb/tb_sobel_window_core.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/sobel_window_core_pkg.sv
// Shared widths and window type for the Sobel window core and its 3x3 window sub-block.
package sobel_window_core_pkg;
  localparam int PIX_W   = 8;
  localparam int RGB_W   = 24;
  localparam int GRAD_W  = 11;
  localparam int COL_W   = 11;
  localparam int MAG_MAX = 255;

  typedef logic [PIX_W-1:0] pix_t;

  // Index [0] is the oldest column, [2] the newest.
  typedef struct packed {
    pix_t [2:0] top;
    pix_t [2:0] mid;
    pix_t [2:0] bot;
  } win_t;
endpackage

// File: rtl/sobel_window_core_win.sv
// 3x3 gray shift window, centre-RGB delay, column counter and stage-0 valid.
module sobel_window_3x3
  import sobel_window_core_pkg::*;
#(
  parameter int IMG_W = 1920
) (
  input  logic             clk,
  input  logic             rst_p,
  input  logic             shift_en_i,
  input  logic             s_ready_i,
  input  logic [PIX_W-1:0] row_top_i,
  input  logic [PIX_W-1:0] row_mid_i,
  input  logic [PIX_W-1:0] row_bot_i,
  input  logic [RGB_W-1:0] rgb_mid_i,
  output win_t             win_o,
  output logic [RGB_W-1:0] rgb_ctr_o,
  output logic [COL_W-1:0] col_o,
  output logic             v0_o
);
  win_t             win_q, win_d;
  logic [RGB_W-1:0] rgb_d1_q, rgb_d1_d, rgb_d2_q, rgb_d2_d;
  logic [COL_W-1:0] col_q, col_d, nxt_q, nxt_d;
  logic             v0_q, v0_d;

  always_comb begin
    win_d    = win_q;
    rgb_d1_d = rgb_d1_q;
    rgb_d2_d = rgb_d2_q;
    col_d    = col_q;
    nxt_d    = nxt_q;
    v0_d     = v0_q;
    if (s_ready_i) begin
      v0_d = shift_en_i;
      if (shift_en_i) begin
        win_d.top = {row_top_i, win_q.top[2:1]};
        win_d.mid = {row_mid_i, win_q.mid[2:1]};
        win_d.bot = {row_bot_i, win_q.bot[2:1]};
        rgb_d1_d  = rgb_mid_i;
        rgb_d2_d  = rgb_d1_q;
        // col tracks the newest column in the window; nxt is the column of the next step.
        col_d     = nxt_q;
        nxt_d     = (nxt_q == COL_W'(IMG_W - 1)) ? '0 : nxt_q + COL_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_p) begin
      win_q    <= '0;
      rgb_d1_q <= '0;
      rgb_d2_q <= '0;
      col_q    <= '0;
      nxt_q    <= '0;
      v0_q     <= 1'b0;
    end else begin
      win_q    <= win_d;
      rgb_d1_q <= rgb_d1_d;
      rgb_d2_q <= rgb_d2_d;
      col_q    <= col_d;
      nxt_q    <= nxt_d;
      v0_q     <= v0_d;
    end
  end

  assign win_o     = win_q;
  assign rgb_ctr_o = rgb_d2_q;
  assign col_o     = col_q;
  assign v0_o      = v0_q;
endmodule

// File: rtl/sobel_window_core.sv
// Sobel edge core: window, gradients, |Gx|+|Gy| with saturation, threshold and border masking.
module sobel_window_core
  import sobel_window_core_pkg::*;
#(
  parameter int IMG_W  = 1920,
  parameter int THRESH = 80
) (
  input  logic             clk,
  input  logic             rst_p,
  input  logic             shift_en,
  input  logic [PIX_W-1:0] row_top,
  input  logic [PIX_W-1:0] row_mid,
  input  logic [PIX_W-1:0] row_bot,
  input  logic [RGB_W-1:0] rgb_mid,
  input  logic             s_ready,
  output logic             o_valid,
  output logic [PIX_W-1:0] o_mag,
  output logic             o_edge,
  output logic             o_border,
  output logic             o_eol,
  output logic [RGB_W-1:0] o_rgb
);
  // (a0 + 2*a1 + a2) - (b0 + 2*b1 + b2); 11-bit signed holds +/-1020 exactly.
  function automatic logic signed [GRAD_W-1:0] sobel_grad(input pix_t a0, input pix_t a1,
      input pix_t a2, input pix_t b0, input pix_t b1, input pix_t b2);
    logic signed [GRAD_W-1:0] pos, neg;
    pos = $signed({3'b0, a0}) + ($signed({3'b0, a1}) <<< 1) + $signed({3'b0, a2});
    neg = $signed({3'b0, b0}) + ($signed({3'b0, b1}) <<< 1) + $signed({3'b0, b2});
    return pos - neg;
  endfunction

  function automatic logic [GRAD_W-1:0] abs_grad(input logic signed [GRAD_W-1:0] g);
    return g[GRAD_W-1] ? $unsigned(-g) : $unsigned(g);
  endfunction

  function automatic pix_t sat_mag(input logic [GRAD_W-1:0] s);
    return (s > GRAD_W'(MAG_MAX)) ? PIX_W'(MAG_MAX) : s[PIX_W-1:0];
  endfunction

  win_t             win;
  logic [RGB_W-1:0] rgb_p0;
  logic [COL_W-1:0] col_p0;
  logic             vld_p0;

  sobel_window_3x3 #(.IMG_W(IMG_W)) u_win (
    .clk       (clk),
    .rst_p     (rst_p),
    .shift_en_i(shift_en),
    .s_ready_i (s_ready),
    .row_top_i (row_top),
    .row_mid_i (row_mid),
    .row_bot_i (row_bot),
    .rgb_mid_i (rgb_mid),
    .win_o     (win),
    .rgb_ctr_o (rgb_p0),
    .col_o     (col_p0),
    .v0_o      (vld_p0)
  );

  logic signed [GRAD_W-1:0] gx_p1_q, gx_p1_d, gy_p1_q, gy_p1_d;
  logic [COL_W-1:0]         col_p1_q, col_p2_q;
  logic [RGB_W-1:0]         rgb_p1_q, rgb_p2_q;
  logic                     vld_p1_q, vld_p2_q, border_p2;
  pix_t                     mag_p2_q, mag_p2_d;

  always_comb begin
    gx_p1_d   = sobel_grad(win.top[2], win.mid[2], win.bot[2], win.top[0], win.mid[0], win.bot[0]);
    gy_p1_d   = sobel_grad(win.bot[0], win.bot[1], win.bot[2], win.top[0], win.top[1], win.top[2]);
    mag_p2_d  = sat_mag(abs_grad(gx_p1_q) + abs_grad(gy_p1_q));
    border_p2 = (col_p2_q < COL_W'(2));
  end

  always_ff @(posedge clk) begin
    if (rst_p) begin
      gx_p1_q  <= '0;
      gy_p1_q  <= '0;
      col_p1_q <= '0;
      rgb_p1_q <= '0;
      vld_p1_q <= 1'b0;
      mag_p2_q <= '0;
      col_p2_q <= '0;
      rgb_p2_q <= '0;
      vld_p2_q <= 1'b0;
      o_valid  <= 1'b0;
      o_mag    <= '0;
      o_edge   <= 1'b0;
      o_border <= 1'b0;
      o_eol    <= 1'b0;
      o_rgb    <= '0;
    end else if (s_ready) begin
      // S1: gradients
      gx_p1_q  <= gx_p1_d;
      gy_p1_q  <= gy_p1_d;
      col_p1_q <= col_p0;
      rgb_p1_q <= rgb_p0;
      vld_p1_q <= vld_p0;
      // S2: magnitude
      mag_p2_q <= mag_p2_d;
      col_p2_q <= col_p1_q;
      rgb_p2_q <= rgb_p1_q;
      vld_p2_q <= vld_p1_q;
      // S3: outputs; border windows still hold the previous line and are masked
      o_valid  <= vld_p2_q;
      o_mag    <= border_p2 ? '0 : mag_p2_q;
      o_edge   <= !border_p2 && (mag_p2_q > PIX_W'(THRESH));
      o_border <= border_p2;
      o_eol    <= (col_p2_q == COL_W'(IMG_W - 1));
      o_rgb    <= rgb_p2_q;
    end
  end
endmodule

// File: tb/tb_sobel_window_core.sv
// Scoreboard bench for sobel_window_core with IMG_W=8, THRESH=80.
module tb_sobel_window_core;
  localparam int IMG_W  = 8;
  localparam int THRESH = 80;

  typedef struct packed {
    logic [7:0]  mag;
    logic        edg;
    logic        border;
    logic        eol;
    logic [23:0] rgb;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_p = 1'b1;
  logic        shift_en = 1'b0;
  logic [7:0]  row_top = '0, row_mid = '0, row_bot = '0;
  logic [23:0] rgb_mid = '0;
  logic        s_ready = 1'b1;
  logic        o_valid, o_edge, o_border, o_eol;
  logic [7:0]  o_mag;
  logic [23:0] o_rgb;

  sobel_window_core #(.IMG_W(IMG_W), .THRESH(THRESH)) dut (
    .clk(clk), .rst_p(rst_p), .shift_en(shift_en), .row_top(row_top), .row_mid(row_mid),
    .row_bot(row_bot), .rgb_mid(rgb_mid), .s_ready(s_ready), .o_valid(o_valid), .o_mag(o_mag),
    .o_edge(o_edge), .o_border(o_border), .o_eol(o_eol), .o_rgb(o_rgb)
  );

  always #5 clk = ~clk;

  int   nvec = 0;
  int   nerr = 0;
  exp_t sb[$];
  int   log_mag[$];
  int   log_edge[$];

  // Reference model state: last three columns per row, last two RGBs, column position.
  int          mp[3][3];
  logic [23:0] mr1, mr2;
  int          mcol, mnxt;

  task automatic model_reset();
    for (int r = 0; r < 3; r++) for (int c = 0; c < 3; c++) mp[r][c] = 0;
    mr1 = '0; mr2 = '0; mcol = 0; mnxt = 0;
  endtask

  task automatic model_push(input int t, input int m, input int b, input logic [23:0] rgb);
    int   nv[3];
    int   gx, gy, s, mag;
    exp_t e;
    nv[0] = t; nv[1] = m; nv[2] = b;
    for (int r = 0; r < 3; r++) begin
      mp[r][0] = mp[r][1]; mp[r][1] = mp[r][2]; mp[r][2] = nv[r];
    end
    mr2 = mr1; mr1 = rgb;
    mcol = mnxt;
    mnxt = (mnxt == IMG_W - 1) ? 0 : mnxt + 1;
    gx = (mp[0][2] + 2 * mp[1][2] + mp[2][2]) - (mp[0][0] + 2 * mp[1][0] + mp[2][0]);
    gy = (mp[2][0] + 2 * mp[2][1] + mp[2][2]) - (mp[0][0] + 2 * mp[0][1] + mp[0][2]);
    s = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
    mag = (s > 255) ? 255 : s;
    e.border = (mcol < 2);
    if (e.border) mag = 0;
    e.mag = 8'(mag);
    e.edg = (mag > THRESH);
    e.eol = (mcol == IMG_W - 1);
    e.rgb = mr2;
    sb.push_back(e);
  endtask

  task automatic step(input logic se, input logic sr, input int t, input int m, input int b,
                      input logic [23:0] rgb);
    shift_en = se; s_ready = sr;
    row_top = 8'(t); row_mid = 8'(m); row_bot = 8'(b); rgb_mid = rgb;
    if (se && sr) model_push(t, m, b, rgb);
    @(posedge clk); #1;
  endtask

  task automatic drain();
    repeat (6) step(1'b0, 1'b1, 0, 0, 0, '0);
    nvec++;
    if (sb.size() != 0) begin
      nerr++;
      $display("FAIL drain: %0d results still expected, want 0", sb.size());
    end
  endtask

  task automatic do_reset();
    shift_en = 1'b0; s_ready = 1'b1; rst_p = 1'b1;
    @(posedge clk); #1;
    rst_p = 1'b0;
    sb.delete();
    model_reset();
    nvec++;
    if ({o_valid, o_mag, o_edge, o_border, o_eol, o_rgb} != '0) begin
      nerr++;
      $display("FAIL reset_outputs: got v=%0b mag=%0d edge=%0b border=%0b eol=%0b rgb=%h, want all 0",
               o_valid, o_mag, o_edge, o_border, o_eol, o_rgb);
    end
  endtask

  // Hand-computed magnitudes of the last emitted line, columns 0..7.
  task automatic check_line(input string name, input int em[8]);
    int base;
    base = log_mag.size() - IMG_W;
    for (int i = 0; i < IMG_W; i++) begin
      nvec++;
      if (base < 0 || log_mag[base + i] != em[i] || log_edge[base + i] != int'(em[i] > THRESH)) begin
        nerr++;
        $display("FAIL %s col%0d: got mag=%0d edge=%0d, want mag=%0d edge=%0d", name, i,
                 (base < 0) ? -1 : log_mag[base + i], (base < 0) ? -1 : log_edge[base + i],
                 em[i], int'(em[i] > THRESH));
      end
    end
  endtask

  // Monitor: a result is taken at the edge following a negedge where o_valid and s_ready are high.
  initial begin
    logic [36:0] snap;
    logic        prev_sr, prev_rst;
    exp_t        e;
    snap = '0; prev_sr = 1'b1; prev_rst = 1'b1;
    forever begin
      @(negedge clk);
      if (!prev_sr && !prev_rst) begin
        nvec++;
        if ({o_valid, o_mag, o_edge, o_border, o_eol, o_rgb} != snap) begin
          nerr++;
          $display("FAIL stall_hold: got %h, want held %h",
                   {o_valid, o_mag, o_edge, o_border, o_eol, o_rgb}, snap);
        end
      end
      if (o_valid && s_ready) begin
        nvec++;
        if (sb.size() == 0) begin
          nerr++;
          $display("FAIL unexpected_out: got mag=%0d border=%0b, want no result", o_mag, o_border);
        end else begin
          e = sb.pop_front();
          if (o_mag !== e.mag || o_edge !== e.edg || o_border !== e.border ||
              o_eol !== e.eol || o_rgb !== e.rgb) begin
            nerr++;
            $display("FAIL result: got mag=%0d edge=%0b border=%0b eol=%0b rgb=%h, want mag=%0d edge=%0b border=%0b eol=%0b rgb=%h",
                     o_mag, o_edge, o_border, o_eol, o_rgb, e.mag, e.edg, e.border, e.eol, e.rgb);
          end
        end
        log_mag.push_back(int'(o_mag));
        log_edge.push_back(int'(o_edge));
      end
      snap = {o_valid, o_mag, o_edge, o_border, o_eol, o_rgb};
      prev_sr = s_ready;
      prev_rst = rst_p;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int v, lat;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Flat field: two lines, everything zero, eol on each line end.
    for (int k = 0; k < 16; k++) step(1'b1, 1'b1, 100, 100, 100, 24'(k + 1));
    drain();
    check_line("flat", '{0, 0, 0, 0, 0, 0, 0, 0});

    // Vertical step edge.
    for (int c = 0; c < 8; c++) begin
      v = (c < 4) ? 0 : 255;
      step(1'b1, 1'b1, v, v, v, {8'(c), 16'h0A0A});
    end
    drain();
    check_line("vstep", '{0, 0, 0, 0, 255, 255, 0, 0});

    // Horizontal step, then a thin mid-row line that cancels in both gradients.
    for (int c = 0; c < 8; c++) step(1'b1, 1'b1, 0, 200, 200, {16'h1111, 8'(c)});
    drain();
    check_line("hstep", '{0, 0, 255, 255, 255, 255, 255, 255});
    for (int c = 0; c < 8; c++) step(1'b1, 1'b1, 0, 10, 0, {16'h2222, 8'(c)});
    drain();
    check_line("midline", '{0, 0, 0, 0, 0, 0, 0, 0});

    // Ramps straddling the threshold.
    for (int c = 0; c < 8; c++) step(1'b1, 1'b1, c * 10, c * 10, c * 10, {8'h33, 8'(c), 8'h00});
    drain();
    check_line("ramp10", '{0, 0, 80, 80, 80, 80, 80, 80});
    for (int c = 0; c < 8; c++) step(1'b1, 1'b1, c * 11, c * 11, c * 11, {8'h44, 8'(c), 8'h00});
    drain();
    check_line("ramp11", '{0, 0, 88, 88, 88, 88, 88, 88});

    // Reset mid-line after column 5, then latency of the first new result.
    for (int c = 0; c < 6; c++) step(1'b1, 1'b1, 50 + c, 60, 70, 24'hABC000 + 24'(c));
    do_reset();
    step(1'b1, 1'b1, 0, 0, 0, 24'h550000);
    shift_en = 1'b0;
    lat = 1;
    while (!o_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    nvec++;
    if (lat != 4 || !o_border) begin
      nerr++;
      $display("FAIL latency: got %0d cycles border=%0b, want 4 cycles border=1", lat, o_border);
    end
    for (int c = 1; c < 8; c++) step(1'b1, 1'b1, c * 10, c * 10, c * 10, 24'h550000 + 24'(c));
    drain();
    check_line("post_reset", '{0, 0, 80, 80, 80, 80, 80, 80});

    // Random stalls and bubbles.
    for (int k = 0; k < 300; k++)
      step(1'($urandom_range(0, 1)), ($urandom_range(0, 9) >= 3), $urandom_range(0, 255),
           $urandom_range(0, 255), $urandom_range(0, 255), 24'($urandom));
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
